// File: rtl/dec_word_align_if.sv
// Signal bundle between the deserializer/decoder and the comma word aligner.
// Names carry the aligner's direction (i_ into it, o_ out of it).
interface dec_word_align_if;
   logic [9:0] i_rx_data;
   logic       i_rx_valid;
   logic       i_code_err;
   logic [9:0] o_sym_out;
   logic       o_sym_valid;
   logic       o_comma_det;
   logic       o_aligned;
   logic [3:0] o_align_off;

   modport slave (
      input  i_rx_data, i_rx_valid, i_code_err,
      output o_sym_out, o_sym_valid, o_comma_det, o_aligned, o_align_off
   );

   modport master (
      output i_rx_data, i_rx_valid, i_code_err,
      input  o_sym_out, o_sym_valid, o_comma_det, o_aligned, o_align_off
   );
endinterface

// File: rtl/dec_word_align.sv
// K28.5 comma word aligner: hunts for the symbol boundary in a 20-bit window,
// locks after repeated commas at one offset and emits aligned symbols to the 8B/10B decoder.
//
// state      | meaning
// ST_HUNT    | no candidate offset, searching every window for a comma
// ST_CONFIRM | candidate offset held, counting commas seen there
// ST_LOCKED  | boundary fixed, symbols emitted, error events counted
module dec_word_align #(
   parameter int CONFIRM_CNT = 3,
   parameter int ERR_LIMIT   = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   dec_word_align_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam logic [3:0] LP_CONFIRM = 4'(CONFIRM_CNT);
   localparam logic [3:0] LP_ERR     = 4'(ERR_LIMIT);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [9:0] r_prev;
   logic [3:0] r_off;
   logic [3:0] w_off_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic [3:0] r_err_cnt;
   logic [3:0] w_err_nxt;
   logic [9:0] r_sym_out;
   logic       r_sym_valid;
   logic       r_comma_det;

   logic [19:0] w_window;
   logic [9:0]  w_cand [10];
   logic [9:0]  w_hit;
   logic        w_any_hit;
   logic [3:0]  w_first_hit;
   logic        w_hit_at_off;
   logic        w_err_ev;
   logic [3:0]  w_cnt_inc;
   logic [3:0]  w_err_inc;

   assign w_window = {r_prev, bus.i_rx_data};

   // Offset k takes the 10 bits starting k positions after the oldest bit of the window.
   for (genvar k = 0; k < 10; k++) begin : g_cand
      assign w_cand[k] = w_window[19-k -: 10];
      assign w_hit[k]  = (w_cand[k][9:3] == 7'b0011111) || (w_cand[k][9:3] == 7'b1100000);
   end

   always_comb begin
      w_first_hit = 4'd0;
      for (int k = 9; k >= 0; k--) begin
         if (w_hit[k]) begin
            w_first_hit = 4'(k);
         end
      end
   end

   assign w_any_hit    = |w_hit;
   assign w_hit_at_off = w_hit[r_off];
   assign w_err_ev     = bus.i_code_err || (bus.i_rx_valid && w_any_hit && !w_hit_at_off);
   assign w_cnt_inc    = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
   assign w_err_inc    = (r_err_cnt == 4'hF) ? r_err_cnt : r_err_cnt + 4'd1;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= ST_HUNT;
         r_off     <= 4'd0;
         r_cnt     <= 4'd0;
         r_err_cnt <= 4'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_off     <= w_off_nxt;
         r_cnt     <= w_cnt_nxt;
         r_err_cnt <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_off_nxt   = r_off;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err_cnt;
      case (r_state)
         ST_HUNT: begin
            if (bus.i_rx_valid && w_any_hit) begin
               w_off_nxt = w_first_hit;
               w_cnt_nxt = 4'd1;
               if (LP_CONFIRM <= 4'd1) begin
                  w_state_nxt = ST_LOCKED;
                  w_err_nxt   = 4'd0;
               end else begin
                  w_state_nxt = ST_CONFIRM;
               end
            end
         end
         ST_CONFIRM: begin
            if (bus.i_code_err) begin
               w_state_nxt = ST_HUNT;
               w_cnt_nxt   = 4'd0;
            end else if (bus.i_rx_valid) begin
               if (w_hit_at_off) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc >= LP_CONFIRM) begin
                     w_state_nxt = ST_LOCKED;
                     w_err_nxt   = 4'd0;
                  end
               end else if (w_any_hit) begin
                  w_off_nxt = w_first_hit;
                  w_cnt_nxt = 4'd1;
               end
            end
         end
         ST_LOCKED: begin
            // A code error and a misplaced comma in the same cycle are one event.
            if (w_err_ev) begin
               w_err_nxt = w_err_inc;
               if (w_err_inc >= LP_ERR) begin
                  w_state_nxt = ST_HUNT;
                  w_err_nxt   = 4'd0;
                  w_cnt_nxt   = 4'd0;
               end
            end else if (bus.i_rx_valid) begin
               w_err_nxt = 4'd0;
            end
         end
         default: begin
            w_state_nxt = ST_HUNT;
            w_cnt_nxt   = 4'd0;
            w_err_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_prev      <= 10'd0;
         r_sym_out   <= 10'd0;
         r_sym_valid <= 1'b0;
         r_comma_det <= 1'b0;
      end else begin
         if (bus.i_rx_valid) begin
            r_prev <= bus.i_rx_data;
         end
         if (r_state == ST_LOCKED && bus.i_rx_valid) begin
            r_sym_out   <= w_cand[r_off];
            r_sym_valid <= 1'b1;
            r_comma_det <= w_hit_at_off;
         end else begin
            r_sym_valid <= 1'b0;
            r_comma_det <= 1'b0;
         end
      end
   end

   assign bus.o_sym_out   = r_sym_out;
   assign bus.o_sym_valid = r_sym_valid;
   assign bus.o_comma_det = r_comma_det;
   assign bus.o_aligned   = (r_state == ST_LOCKED);
   assign bus.o_align_off = r_off;

endmodule

// File: tb/tb_dec_word_align.sv
// Directed bench for the comma word aligner: lock at several offsets, candidate
// switching, loss of sync, rx_valid gaps and asynchronous reset.
module tb_dec_word_align;

   logic i_clk;
   logic i_reset;
   int   n_assert;
   int   n_fail;

   dec_word_align_if bus ();

   dec_word_align #(.CONFIRM_CNT(3), .ERR_LIMIT(4)) u_dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus.slave)
   );

   localparam logic [9:0] C_N  = 10'b0011111010;
   localparam logic [9:0] C_P  = 10'b1100000101;
   localparam logic [9:0] S3_1 = 10'b0000011111;
   localparam logic [9:0] S3_2 = 10'b0101100000;
   localparam logic [9:0] S3_3 = 10'b1010011111;
   localparam logic [9:0] W_F  = 10'b0101010101;
   localparam logic [9:0] W_A  = 10'b0000011111;
   localparam logic [9:0] W_C  = 10'b0101010001;
   localparam logic [9:0] W_D  = 10'b1111010001;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, return 1 ns after the capturing edge.
   task automatic step(input logic valid, input logic [9:0] data, input logic err);
      bus.i_rx_valid = valid;
      bus.i_rx_data  = data;
      bus.i_code_err = err;
      @(posedge i_clk);
      #1;
      bus.i_rx_valid = 1'b0;
      bus.i_code_err = 1'b0;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_assert       = 0;
      n_fail         = 0;
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 10'd0;
      bus.i_code_err = 1'b0;
      i_reset        = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      i_reset = 1'b0;

      chk("rst_aligned", {9'd0, bus.o_aligned}, 10'd0);
      chk("rst_off", {6'd0, bus.o_align_off}, 10'd0);
      chk("rst_valid", {9'd0, bus.o_sym_valid}, 10'd0);
      chk("rst_sym", bus.o_sym_out, 10'd0);
      chk("rst_comma", {9'd0, bus.o_comma_det}, 10'd0);

      // T1: offset 0, lock after the 4th word (first comma only visible once it is prev_word)
      step(1, C_N, 0);
      step(1, C_P, 0);
      step(1, C_N, 0);
      chk("t1_not_yet", {9'd0, bus.o_aligned}, 10'd0);
      step(1, C_P, 0);
      chk("t1_aligned", {9'd0, bus.o_aligned}, 10'd1);
      chk("t1_off", {6'd0, bus.o_align_off}, 10'd0);
      chk("t1_entry_novalid", {9'd0, bus.o_sym_valid}, 10'd0);
      step(1, C_N, 0);
      chk("t1_sym0", bus.o_sym_out, C_P);
      chk("t1_valid0", {9'd0, bus.o_sym_valid}, 10'd1);
      chk("t1_comma0", {9'd0, bus.o_comma_det}, 10'd1);
      step(1, C_P, 0);
      chk("t1_sym1", bus.o_sym_out, C_N);
      step(0, 10'd0, 0);
      chk("t1_idle_valid", {9'd0, bus.o_sym_valid}, 10'd0);
      chk("t1_idle_hold", bus.o_sym_out, C_N);
      chk("t1_idle_comma", {9'd0, bus.o_comma_det}, 10'd0);

      // T2: same bitstream delayed 3 bits
      do_reset();
      step(1, S3_1, 0);
      step(1, S3_2, 0);
      chk("t2_cand", {6'd0, bus.o_align_off}, 10'd3);
      chk("t2_cand_unaligned", {9'd0, bus.o_aligned}, 10'd0);
      step(1, S3_3, 0);
      step(1, S3_2, 0);
      chk("t2_aligned", {9'd0, bus.o_aligned}, 10'd1);
      chk("t2_off", {6'd0, bus.o_align_off}, 10'd3);
      step(1, S3_3, 0);
      chk("t2_sym0", bus.o_sym_out, C_P);
      chk("t2_comma0", {9'd0, bus.o_comma_det}, 10'd1);
      step(1, S3_2, 0);
      chk("t2_sym1", bus.o_sym_out, C_N);

      // T3: two commas at offset 3, then a comma at 7 restarts the count
      do_reset();
      step(1, W_F, 0);
      step(1, W_A, 0);
      step(1, W_A, 0);
      chk("t3_cand3", {6'd0, bus.o_align_off}, 10'd3);
      step(1, W_C, 0);
      chk("t3_cnt2_unaligned", {9'd0, bus.o_aligned}, 10'd0);
      step(1, W_D, 0);
      chk("t3_cand7", {6'd0, bus.o_align_off}, 10'd7);
      chk("t3_switch_unaligned", {9'd0, bus.o_aligned}, 10'd0);
      step(1, W_D, 0);
      chk("t3_cnt2_at7", {9'd0, bus.o_aligned}, 10'd0);
      step(1, W_D, 0);
      chk("t3_aligned", {9'd0, bus.o_aligned}, 10'd1);
      chk("t3_off", {6'd0, bus.o_align_off}, 10'd7);
      step(1, W_D, 0);
      chk("t3_sym", bus.o_sym_out, C_N);
      chk("t3_comma", {9'd0, bus.o_comma_det}, 10'd1);

      // T4: error counting while locked at 7
      step(1, W_F, 1);
      chk("t4_sym_noncomma", bus.o_sym_out, 10'b0010101010);
      chk("t4_comma_noncomma", {9'd0, bus.o_comma_det}, 10'd0);
      step(1, W_F, 1);
      step(1, W_F, 1);
      chk("t4_three_err", {9'd0, bus.o_aligned}, 10'd1);
      step(1, W_F, 0);
      chk("t4_clean", {9'd0, bus.o_aligned}, 10'd1);
      step(1, W_F, 1);
      step(1, W_F, 1);
      step(0, 10'd0, 1);
      chk("t4_cnt_cleared", {9'd0, bus.o_aligned}, 10'd1);
      step(1, W_F, 1);
      chk("t4_lost", {9'd0, bus.o_aligned}, 10'd0);
      step(0, 10'd0, 0);
      chk("t4_lost_valid", {9'd0, bus.o_sym_valid}, 10'd0);

      // code_err during CONFIRM sends the aligner back to HUNT
      do_reset();
      step(1, C_N, 0);
      step(1, C_P, 0);
      step(1, C_N, 0);
      step(0, 10'd0, 1);
      step(1, C_P, 0);
      chk("cerr_restart", {9'd0, bus.o_aligned}, 10'd0);
      step(1, C_N, 0);
      chk("cerr_cnt2", {9'd0, bus.o_aligned}, 10'd0);
      step(1, C_P, 0);
      chk("cerr_relock", {9'd0, bus.o_aligned}, 10'd1);

      // T5: rx_valid only every third cycle
      do_reset();
      step(1, C_N, 0);
      step(0, 10'd0, 0);
      step(0, 10'd0, 0);
      step(1, C_P, 0);
      step(0, 10'd0, 0);
      step(0, 10'd0, 0);
      step(1, C_N, 0);
      step(0, 10'd0, 0);
      step(0, 10'd0, 0);
      chk("t5_gap_unaligned", {9'd0, bus.o_aligned}, 10'd0);
      step(1, C_P, 0);
      chk("t5_aligned", {9'd0, bus.o_aligned}, 10'd1);
      step(0, 10'd0, 0);
      chk("t5_gap_novalid0", {9'd0, bus.o_sym_valid}, 10'd0);
      step(0, 10'd0, 0);
      step(1, C_N, 0);
      chk("t5_valid", {9'd0, bus.o_sym_valid}, 10'd1);
      chk("t5_sym", bus.o_sym_out, C_P);
      step(0, 10'd0, 0);
      chk("t5_gap_novalid1", {9'd0, bus.o_sym_valid}, 10'd0);
      chk("t5_gap_hold", bus.o_sym_out, C_P);

      // T6: asynchronous reset mid-CONFIRM and mid-LOCKED
      do_reset();
      step(1, S3_1, 0);
      step(1, S3_2, 0);
      step(1, S3_3, 0);
      chk("t6_pre_off", {6'd0, bus.o_align_off}, 10'd3);
      #2;
      i_reset = 1'b1;
      #1;
      chk("t6_conf_off", {6'd0, bus.o_align_off}, 10'd0);
      chk("t6_conf_aligned", {9'd0, bus.o_aligned}, 10'd0);
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      step(1, S3_3, 0);
      step(1, S3_2, 0);
      step(1, S3_3, 0);
      chk("t6_relock_two", {9'd0, bus.o_aligned}, 10'd0);
      step(1, S3_2, 0);
      chk("t6_relock", {9'd0, bus.o_aligned}, 10'd1);
      step(1, S3_3, 0);
      chk("t6_lock_sym", bus.o_sym_out, C_P);
      chk("t6_lock_valid", {9'd0, bus.o_sym_valid}, 10'd1);
      #2;
      i_reset = 1'b1;
      #1;
      chk("t6_lck_aligned", {9'd0, bus.o_aligned}, 10'd0);
      chk("t6_lck_valid", {9'd0, bus.o_sym_valid}, 10'd0);
      chk("t6_lck_sym", bus.o_sym_out, 10'd0);
      chk("t6_lck_comma", {9'd0, bus.o_comma_det}, 10'd0);
      chk("t6_lck_off", {6'd0, bus.o_align_off}, 10'd0);
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
